decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/common_pkg.sv | 82 ++++++++
 rtl/register_file.sv | 47 ++++
 rtl/decode_stage.sv | 80 ++++++++
 tb/tb_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared decode types: ALU operations, fetch/decode/execute payloads and
// the opcode/funct decode helper used by decode_stage.
package common;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_type;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_type;

    typedef struct packed {
        logic [4:0]      pc;
        instruction_type instruction;
    } if_id_type;

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
        alu_op_type  alu_op;
        logic [4:0]  rd;
        logic [4:0]  pc;
        logic        illegal;
    } id_ex_type;

    typedef struct packed {
        logic       legal;
        logic       use_rs2;
        alu_op_type alu_op;
    } decode_ctrl_type;

    // Classify an instruction: legal or not, register or immediate
    // second operand, and which ALU operation it requests.
    function automatic decode_ctrl_type decode_ctrl(input instruction_type insn);
        decode_ctrl_type ctrl;
        ctrl = '{legal: 1'b0, use_rs2: 1'b0, alu_op: ALU_ADD};
        if (insn.opcode == OPCODE_OP) begin
            ctrl.use_rs2 = 1'b1;
            if (insn.funct3 == FUNCT3_ADD_SUB && insn.funct7 == FUNCT7_BASE) begin
                ctrl.legal  = 1'b1;
                ctrl.alu_op = ALU_ADD;
            end else if (insn.funct3 == FUNCT3_ADD_SUB && insn.funct7 == FUNCT7_ALT) begin
                ctrl.legal  = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end else if (insn.funct3 == FUNCT3_AND && insn.funct7 == FUNCT7_BASE) begin
                ctrl.legal  = 1'b1;
                ctrl.alu_op = ALU_AND;
            end else if (insn.funct3 == FUNCT3_OR && insn.funct7 == FUNCT7_BASE) begin
                ctrl.legal  = 1'b1;
                ctrl.alu_op = ALU_OR;
            end
        end else if (insn.opcode == OPCODE_OP_IMM) begin
            case (insn.funct3)
                FUNCT3_ADD_SUB: begin ctrl.legal = 1'b1; ctrl.alu_op = ALU_ADD; end
                FUNCT3_AND:     begin ctrl.legal = 1'b1; ctrl.alu_op = ALU_AND; end
                FUNCT3_OR:      begin ctrl.legal = 1'b1; ctrl.alu_op = ALU_OR;  end
                default:        ctrl.legal = 1'b0;
            endcase
        end
        return ctrl;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32 x 32-bit register file, two combinational read ports, one write port.
// x0 always reads 0 and ignores writes.
// Build option DECODE_WB_BYPASS_EN: a read of the register being written in
// the same cycle returns the write data instead of the stored value.
module register_file (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] regs [32];
    logic        wr_hit;

    assign wr_hit = wr_en && (wr_addr != 5'd0);

    // Storage update: clear on reset, otherwise write the addressed entry.
    // NOTE: the array has a reset because every entry must read 0 after reset;
    // that rules out mapping it onto a reset-less RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                // NOTE: non-blocking assignment for all sequential state.
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read ports with x0 forced to zero and optional write-through.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        rd_data1 = (rd_addr1 == 5'd0) ? 32'd0 : regs[rd_addr1];
        rd_data2 = (rd_addr2 == 5'd0) ? 32'd0 : regs[rd_addr2];
`ifdef DECODE_WB_BYPASS_EN
        if (wr_hit && (wr_addr == rd_addr1)) rd_data1 = wr_data;
        if (wr_hit && (wr_addr == rd_addr2)) rd_data2 = wr_data;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: slices the fetched instruction, reads operands from the
// register file and presents a one-cycle-latency valid/ready payload to
// execute. Illegal encodings pass through as marked bubbles.
// Build option DECODE_WB_BYPASS_EN: same-cycle writeback forwarding in the
// register file.
module decode_stage
    import common::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_id_valid,
    input  if_id_type   if_id,
    output logic        if_id_ready,
    output logic        id_ex_valid,
    output id_ex_type   id_ex,
    input  logic        id_ex_ready,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);

    instruction_type insn;
    decode_ctrl_type ctrl;
    logic [31:0]     rs1_data;
    logic [31:0]     rs2_data;
    logic [31:0]     imm_sext;
    id_ex_type       next_payload;
    logic            accept;

    assign insn     = if_id.instruction;
    assign ctrl     = decode_ctrl(insn);
    assign imm_sext = {{20{insn.funct7[6]}}, insn.funct7, insn.rs2};

    register_file u_register_file (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_addr1 (insn.rs1),
        .rd_addr2 (insn.rs2),
        .rd_data1 (rs1_data),
        .rd_data2 (rs2_data),
        .wr_en    (wb_en),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // The output register can take a new payload when empty or being drained.
    assign if_id_ready = !id_ex_valid || id_ex_ready;
    assign accept      = if_id_valid && if_id_ready;

    // Build the execute payload; illegal encodings become zeroed bubbles.
    always_comb begin
        next_payload    = '0;
        next_payload.pc = if_id.pc;
        if (ctrl.legal) begin
            next_payload.data1  = rs1_data;
            next_payload.data2  = ctrl.use_rs2 ? rs2_data : imm_sext;
            next_payload.alu_op = ctrl.alu_op;
            next_payload.rd     = insn.rd;
        end else begin
            next_payload.illegal = 1'b1;
        end
    end

    // Output register: flush empties it, accept loads it, consume drains it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_ex_valid <= 1'b0;
            id_ex       <= '0;
        end else if (flush) begin
            id_ex_valid <= 1'b0;
        end else if (accept) begin
            id_ex_valid <= 1'b1;
            id_ex       <= next_payload;
        end else if (id_ex_ready) begin
            id_ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by
// randomized traffic compared against a behavioural model.
module tb_decode_stage;
    import common::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_id_valid = 1'b0;
    if_id_type   if_id = '0;
    logic        if_id_ready;
    logic        id_ex_valid;
    id_ex_type   id_ex;
    logic        id_ex_ready = 1'b0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;

    int checks = 0;
    int failures = 0;

    logic [31:0] rf_model [32];
    logic        exp_valid;
    id_ex_type   exp_ex;

`ifdef DECODE_WB_BYPASS_EN
    localparam logic [31:0] SUB_EXP_DATA1 = 32'd9;
`else
    localparam logic [31:0] SUB_EXP_DATA1 = 32'd5;
`endif

    decode_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_id_valid (if_id_valid),
        .if_id       (if_id),
        .if_id_ready (if_id_ready),
        .id_ex_valid (id_ex_valid),
        .id_ex       (id_ex),
        .id_ex_ready (id_ex_ready),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model register read as seen by decode this cycle.
    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_rd != 5'd0 && wb_rd == a) return wb_data;
`endif
        return rf_model[a];
    endfunction

    // Expected payload from the instruction-set rules.
    function automatic id_ex_type ref_decode(input logic [31:0] ins, input logic [4:0] pc);
        id_ex_type  r;
        logic       is_r;
        logic       is_i;
        logic       ok;
        alu_op_type sel;
        r    = '0;
        r.pc = pc;
        is_r = (ins[6:0] == 7'h33);
        is_i = (ins[6:0] == 7'h13);
        ok   = 1'b1;
        sel  = ALU_ADD;
        if (is_r) begin
            case ({ins[31:25], ins[14:12]})
                10'b0000000_000: sel = ALU_ADD;
                10'b0100000_000: sel = ALU_SUB;
                10'b0000000_111: sel = ALU_AND;
                10'b0000000_110: sel = ALU_OR;
                default:         ok  = 1'b0;
            endcase
        end else if (is_i) begin
            case (ins[14:12])
                3'd0:    sel = ALU_ADD;
                3'd7:    sel = ALU_AND;
                3'd6:    sel = ALU_OR;
                default: ok  = 1'b0;
            endcase
        end else begin
            ok = 1'b0;
        end
        if (ok) begin
            r.data1  = ref_read(ins[19:15]);
            r.data2  = is_r ? ref_read(ins[24:20]) : 32'($signed(ins[31:20]));
            r.alu_op = sel;
            r.rd     = ins[11:7];
        end else begin
            r.illegal = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        rd  = 5'($urandom);
        case ($urandom_range(0, 3))
            0: begin
                case ($urandom_range(0, 3))
                    0:       begin f7 = 7'h00; f3 = 3'd0; end
                    1:       begin f7 = 7'h20; f3 = 3'd0; end
                    2:       begin f7 = 7'h00; f3 = 3'd7; end
                    default: begin f7 = 7'h00; f3 = 3'd6; end
                endcase
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            1: begin
                f3 = ($urandom_range(0, 2) == 0) ? 3'd0 : (($urandom_range(0, 1) == 0) ? 3'd7 : 3'd6);
                return {12'($urandom), rs1, f3, rd, 7'h13};
            end
            2: return $urandom;
            default: begin
                f7 = 7'($urandom);
                f3 = 3'($urandom);
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [4:0] pc,
                         input logic rdy, input logic fl,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        if_id_valid = v;
        if_id       = {pc, ins};
        id_ex_ready = rdy;
        flush       = fl;
        wb_en       = we;
        wb_rd       = wrd;
        wb_data     = wd;
    endtask

    // One clock: check handshake, advance the model, clock, check outputs.
    task automatic tick();
        logic ready_m;
        #1;
        ready_m = !exp_valid || id_ex_ready;
        check("if_id_ready", if_id_ready, ready_m);
        if (flush) begin
            exp_valid = 1'b0;
        end else if (if_id_valid && ready_m) begin
            exp_valid = 1'b1;
            exp_ex    = ref_decode(if_id[31:0], if_id[36:32]);
        end else if (id_ex_ready) begin
            exp_valid = 1'b0;
        end
        if (wb_en && wb_rd != 5'd0) rf_model[wb_rd] = wb_data;
        @(posedge clk);
        #1;
        check("id_ex_valid", id_ex_valid, exp_valid);
        if (exp_valid) check("id_ex", id_ex, exp_ex);
    endtask

    // Assert reset (asynchronously), confirm immediate clear, then release.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, "_valid"}, id_ex_valid, 1'b0);
        check({tag, "_id_ex"}, id_ex, '0);
        exp_valid = 1'b0;
        exp_ex    = '0;
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset("rst_init");

        // Fill x1=5, x2=3 through the writeback port.
        drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 32'd5);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'd3);
        tick();

        // ADD x3,x1,x2
        drive(1'b1, 32'h002081B3, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("add_valid", id_ex_valid, 1'b1);
        check("add_data1", id_ex.data1, 32'd5);
        check("add_data2", id_ex.data2, 32'd3);
        check("add_alu", id_ex.alu_op, ALU_ADD);
        check("add_rd", id_ex.rd, 5'd3);

        // ADDI x4,x1,-1
        drive(1'b1, 32'hFFF08213, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("addi_data1", id_ex.data1, 32'd5);
        check("addi_data2", id_ex.data2, 32'hFFFF_FFFF);
        check("addi_alu", id_ex.alu_op, ALU_ADD);
        check("addi_rd", id_ex.rd, 5'd4);

        // Back-pressure for 3 cycles with AND x6,x1,x2 waiting.
        drive(1'b1, 32'h0020F333, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_ready", if_id_ready, 1'b0);
            check("hold_rd", id_ex.rd, 5'd4);
            check("hold_data2", id_ex.data2, 32'hFFFF_FFFF);
        end
        id_ex_ready = 1'b1;
        tick();
        check("release_valid", id_ex_valid, 1'b1);
        check("release_rd", id_ex.rd, 5'd6);
        check("release_alu", id_ex.alu_op, ALU_AND);

        // SUB x5,x1,x2 with concurrent writeback x1=9.
        drive(1'b1, 32'h402082B3, 5'd4, 1'b1, 1'b0, 1'b1, 5'd1, 32'd9);
        tick();
        check("sub_data1", id_ex.data1, SUB_EXP_DATA1);
        check("sub_data2", id_ex.data2, 32'd3);
        check("sub_alu", id_ex.alu_op, ALU_SUB);
        check("sub_rd", id_ex.rd, 5'd5);

        // Hold the SUB, then flush with new input and a write to x0.
        drive(1'b1, 32'h000003B3, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("pre_flush_valid", id_ex_valid, 1'b1);
        drive(1'b1, 32'h000003B3, 5'd5, 1'b0, 1'b1, 1'b1, 5'd0, 32'd7);
        tick();
        check("flush_valid", id_ex_valid, 1'b0);

        // ADD x7,x0,x0 must still see x0 as zero.
        drive(1'b1, 32'h000003B3, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("x0_data1", id_ex.data1, 32'd0);
        check("x0_data2", id_ex.data2, 32'd0);
        check("x0_rd", id_ex.rd, 5'd7);

        // Load opcode is illegal and flows as a bubble.
        drive(1'b1, 32'h0000A183, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("illegal_valid", id_ex_valid, 1'b1);
        check("illegal_flag", id_ex.illegal, 1'b1);
        check("illegal_rd", id_ex.rd, 5'd0);
        check("illegal_data1", id_ex.data1, 32'd0);
        check("illegal_pc", id_ex.pc, 5'd7);

        // Reset while a valid payload is held, then accept right after release.
        drive(1'b1, 32'h002081B3, 5'd8, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        do_reset("rst_mid");
        drive(1'b1, 32'h002081B3, 5'd9, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        check("post_rst_valid", id_ex_valid, 1'b1);
        check("post_rst_data1", id_ex.data1, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, rand_insn(), 5'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
